wb_write_arbiter: RTL and testbench

- Owns the single register-file write port.
- Shares the port between the in-order pipeline writeback (output of the WB stage) and a multi-cycle auxiliary unit, e.g. mul/div, that completes out of band.
- Auxiliary results are queued in a small FIFO and drained into idle write slots.
- If the pipeline never leaves an idle slot, a starvation counter forces a one-cycle pipeline stall.

---
 rtl/wb_write_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_wb_write_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: owns the single register-file write port and shares it
//   between the in-order pipeline writeback and a queued out-of-band aux unit.
// Latency: the WB write is combinational (0 cycles); aux results are written at
//   least 1 cycle after acceptance; a waiting aux head forces a 1-cycle stall.
// Backpressure: aux_ready_o = !full (valid/ready); the pipeline is throttled only
//   through pipe_stall_o, a registered single-cycle pulse.
//
// Ports:
//   clk_i, rst_i                  clock (rising edge), async active-high reset
//   wb_we_i/wb_dst_i/wb_data_i    pipeline writeback request from the WB stage
//   aux_valid_i/aux_ready_o       aux result handshake (transfer on valid&&ready)
//   aux_dst_i/aux_data_i          aux result payload (dst 0 is dropped)
//   rf_we_o/rf_dst_o/rf_data_o    register-file write port
//   pipe_stall_o                  freeze the pipeline (incl. WB) this cycle
//   aux_pending_o                 aux FIFO non-empty
//   stall_count_o                 (WB_ARB_PERF_EN only) saturating stall-cycle count
//
// Optional build macro: WB_ARB_PERF_EN adds the stall_count_o port and counter.

// wb_arb_fifo: small generic FIFO, power-of-two depth, head exposed combinationally.
// Latency: an entry pushed at edge N is visible at the head from cycle N+1 (no bypass).
// Backpressure: push ignored while full, pop ignored while empty.
module wb_arb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign head_dat_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Depth is a power of two, so plain pointer overflow gives the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: reset empties the FIFO through the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

endmodule

module wb_write_arbiter #(
  parameter int AUX_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_dst_i,
  input  logic [31:0] wb_data_i,
  input  logic        aux_valid_i,
  output logic        aux_ready_o,
  input  logic [4:0]  aux_dst_i,
  input  logic [31:0] aux_data_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_dst_o,
  output logic [31:0] rf_data_o,
  output logic        pipe_stall_o,
  output logic        aux_pending_o
`ifdef WB_ARB_PERF_EN
  ,
  output logic [15:0] stall_count_o
`endif
);

  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] data;
  } aux_entry_t;

  localparam logic [3:0] STARVE_LIM = STARVE_LIMIT[3:0];

  aux_entry_t head;
  aux_entry_t push_ent;
  logic       fifo_full, fifo_empty;
  logic       fifo_push, fifo_pop;

  logic [3:0] starve_q, starve_d;
  logic       stall_q, stall_d;

  // ---------------------------------------------------------------------------
  // Aux queue. Ready is purely !full so it never depends on this cycle's pop.
  // Writes to r0 complete the handshake but are dropped instead of queued.
  // ---------------------------------------------------------------------------
  assign aux_ready_o   = !fifo_full && !rst_i;
  assign fifo_push     = aux_valid_i && aux_ready_o && (aux_dst_i != 5'd0);
  assign push_ent.dst  = aux_dst_i;
  assign push_ent.data = aux_data_i;
  assign aux_pending_o = !fifo_empty;

  wb_arb_fifo #(
    .WIDTH ($bits(aux_entry_t)),
    .DEPTH (AUX_DEPTH)
  ) u_aux_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (fifo_push),
    .push_dat_i (push_ent),
    .pop_i      (fifo_pop),
    .head_dat_o (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Write-port grant. During a forced stall the WB instruction is frozen and
  // re-presented next cycle, so its wb_we is ignored and the head goes out.
  // ---------------------------------------------------------------------------
  always_comb begin
    rf_we_o   = 1'b0;
    rf_dst_o  = 5'd0;
    rf_data_o = 32'd0;
    fifo_pop  = 1'b0;
    if (rst_i) begin
      // Port stays quiet while reset is held, whatever the WB stage shows.
      fifo_pop = 1'b0;
    end else if (stall_q) begin
      if (!fifo_empty) begin
        rf_we_o   = 1'b1;
        rf_dst_o  = head.dst;
        rf_data_o = head.data;
        fifo_pop  = 1'b1;
      end
    end else if (wb_we_i) begin
      rf_we_o   = 1'b1;
      rf_dst_o  = wb_dst_i;
      rf_data_o = wb_data_i;
    end else if (!fifo_empty) begin
      rf_we_o   = 1'b1;
      rf_dst_o  = head.dst;
      rf_data_o = head.data;
      fifo_pop  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation tracking: counts cycles the head has been passed over. The
  // stall is raised at the same edge the count reaches the limit; the pop
  // made during the stall clears the count, so stalls can never be adjacent.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (fifo_empty || fifo_pop) begin
      starve_d = 4'd0;
    end else if (starve_q == 4'hF) begin
      starve_d = starve_q;
    end else begin
      starve_d = starve_q + 4'd1;
    end
    stall_d = !stall_q && (starve_d == STARVE_LIM);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= 4'd0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign pipe_stall_o = stall_q;

`ifdef WB_ARB_PERF_EN
  // Saturating count of stalled cycles.
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_q && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed scenarios plus randomized traffic for wb_write_arbiter.
// Outputs are sampled 1ns after the falling edge; the model advances on the rising edge.
// The reference model keeps the aux queue as a SystemVerilog queue of entries.
module tb_wb_write_arbiter;

  localparam int AUX_DEPTH    = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_dst;
  logic [31:0] aux_data;
  logic        rf_we;
  logic [4:0]  rf_dst;
  logic [31:0] rf_data;
  logic        pipe_stall;
  logic        aux_pending;
`ifdef WB_ARB_PERF_EN
  logic [15:0] stall_count;
`endif

  wb_write_arbiter #(
    .AUX_DEPTH    (AUX_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .wb_we_i       (wb_we),
    .wb_dst_i      (wb_dst),
    .wb_data_i     (wb_data),
    .aux_valid_i   (aux_valid),
    .aux_ready_o   (aux_ready),
    .aux_dst_i     (aux_dst),
    .aux_data_i    (aux_data),
    .rf_we_o       (rf_we),
    .rf_dst_o      (rf_dst),
    .rf_data_o     (rf_data),
    .pipe_stall_o  (pipe_stall),
    .aux_pending_o (aux_pending)
`ifdef WB_ARB_PERF_EN
    ,
    .stall_count_o (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];          // queued aux results, oldest first
  int   m_wait;         // cycles the current head has been passed over
  bit   m_stall;        // stall pulse in the current cycle
  int   m_scount;       // stalled cycles seen since reset (saturating)
  bit   m_gnt_head;     // this cycle's grant went to the queue head
  bit   m_ready;        // this cycle's expected aux_ready

  task automatic model_reset();
    mq.delete();
    m_wait   = 0;
    m_stall  = 0;
    m_scount = 0;
  endtask

  // Apply one cycle of inputs on the falling edge and check every output.
  task automatic drive(input logic we, input logic [4:0] dst, input logic [31:0] dat,
                       input logic av, input logic [4:0] adst, input logic [31:0] adat);
    logic        e_we;
    logic [4:0]  e_dst;
    logic [31:0] e_data;
    @(negedge clk);
    wb_we = we; wb_dst = dst; wb_data = dat;
    aux_valid = av; aux_dst = adst; aux_data = adat;
    #1;
    m_ready    = (mq.size() < AUX_DEPTH);
    m_gnt_head = 1'b0;
    e_we = 1'b0; e_dst = 5'd0; e_data = 32'd0;
    if (m_stall) begin
      m_gnt_head = (mq.size() > 0);
    end else if (we) begin
      e_we = 1'b1; e_dst = dst; e_data = dat;
    end else begin
      m_gnt_head = (mq.size() > 0);
    end
    if (m_gnt_head) begin
      e_we = 1'b1; e_dst = mq[0].dst; e_data = mq[0].data;
    end
    chk("rf_we",       {31'd0, rf_we},       {31'd0, e_we});
    chk("rf_dst",      {27'd0, rf_dst},      {27'd0, e_dst});
    chk("rf_data",     rf_data,              e_data);
    chk("pipe_stall",  {31'd0, pipe_stall},  {31'd0, m_stall});
    chk("aux_ready",   {31'd0, aux_ready},   {31'd0, m_ready});
    chk("aux_pending", {31'd0, aux_pending}, {31'd0, (mq.size() > 0)});
`ifdef WB_ARB_PERF_EN
    chk("stall_count", {16'd0, stall_count}, m_scount);
`endif
  endtask

  // Advance the model across the rising edge.
  task automatic tick();
    bit had_head;
    @(posedge clk);
    had_head = (mq.size() > 0);
    if (m_gnt_head) void'(mq.pop_front());
    if (aux_valid && m_ready && (aux_dst != 5'd0)) mq.push_back({aux_dst, aux_data});
    if (!had_head || m_gnt_head) m_wait = 0;
    else m_wait++;
    if (m_stall && m_scount < 16'hFFFF) m_scount++;
    m_stall = !m_stall && (m_wait == STARVE_LIMIT);
  endtask

  // Assert reset mid-cycle, check the forced outputs, release on a falling edge.
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("rst_stall",   {31'd0, pipe_stall},  32'd0);
    chk("rst_pending", {31'd0, aux_pending}, 32'd0);
    chk("rst_ready",   {31'd0, aux_ready},   32'd0);
    chk("rst_rf_we",   {31'd0, rf_we},       32'd0);
    chk("rst_rf_dst",  {27'd0, rf_dst},      32'd0);
    chk("rst_rf_data", rf_data,              32'd0);
`ifdef WB_ARB_PERF_EN
    chk("rst_scount",  {16'd0, stall_count}, 32'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    wb_we = 1'b0; aux_valid = 1'b0;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    wb_we = 1'b1; wb_dst = 5'd1; wb_data = 32'h1;
    aux_valid = 1'b1; aux_dst = 5'd2; aux_data = 32'h2;
    model_reset();
    @(negedge clk);
    pulse_reset();

    // First cycle after reset release, idle inputs.
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("rel_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rel_stall", {31'd0, pipe_stall}, 32'd0);
    chk("rel_ready", {31'd0, aux_ready}, 32'd1);
    tick();

    // Pipeline write passes straight through.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    chk("wb_rf_we",   {31'd0, rf_we}, 32'd1);
    chk("wb_rf_dst",  {27'd0, rf_dst}, 32'd5);
    chk("wb_rf_data", rf_data, 32'hDEADBEEF);
    tick();

    // Aux push at N, written at N+1, queue empty at N+2.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678);
    chk("aux_n_rf_we", {31'd0, rf_we}, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("aux_n1_rf_we",   {31'd0, rf_we}, 32'd1);
    chk("aux_n1_rf_dst",  {27'd0, rf_dst}, 32'd7);
    chk("aux_n1_rf_data", rf_data, 32'h12345678);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("aux_n2_pending", {31'd0, aux_pending}, 32'd0);
    tick();

    // Fill the queue under continuous WB traffic and reach a forced stall.
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd3, 32'hA3);
    chk("fill1_ready", {31'd0, aux_ready}, 32'd1);
    tick();
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd4, 32'hA4);
    chk("fill2_ready", {31'd0, aux_ready}, 32'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd6, 32'hA6);
      chk("full_ready", {31'd0, aux_ready}, 32'd0);
      chk("full_nostall", {31'd0, pipe_stall}, 32'd0);
      tick();
    end
    drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
    chk("stall_hi",      {31'd0, pipe_stall}, 32'd1);
    chk("stall_rf_we",   {31'd0, rf_we}, 32'd1);
    chk("stall_rf_dst",  {27'd0, rf_dst}, 32'd3);
    chk("stall_rf_data", rf_data, 32'hA3);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("post_stall_lo",    {31'd0, pipe_stall}, 32'd0);
    chk("post_stall_ready", {31'd0, aux_ready}, 32'd1);
    chk("post_stall_dst",   {27'd0, rf_dst}, 32'd4);
    tick();

    // Aux result to r0 is accepted and dropped.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD);
    chk("r0_ready", {31'd0, aux_ready}, 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("r0_pending", {31'd0, aux_pending}, 32'd0);
    chk("r0_rf_we",   {31'd0, rf_we}, 32'd0);
    tick();

    // Reset while full and stalling.
    drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd10, 32'hB0);
    tick();
    drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd11, 32'hB1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'd0);
      tick();
    end
    drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd12, 32'hB2);
    chk("pre_rst_stall",   {31'd0, pipe_stall}, 32'd1);
    chk("pre_rst_pending", {31'd0, aux_pending}, 32'd1);
    pulse_reset();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) < 75), 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 299) == 0) pulse_reset();
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
